// File: rtl/rng_pkg.sv
// Shared types, default tap masks and the Fibonacci LFSR step used by the
// random-number generator and its core.
package rng_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

    localparam int MAX_WIDTH = 16;

    // Maximal-length feedback masks for the widths the game uses.
    localparam logic [4:0]  TAPS_W5  = 5'b10100;
    localparam logic [7:0]  TAPS_W8  = 8'b10111000;
    localparam logic [15:0] TAPS_W16 = 16'hB400;

    // Shift left by one, new bit0 = parity of the tapped bits, result
    // trimmed to the active width (inputs are zero-extended to MAX_WIDTH).
    function automatic logic [MAX_WIDTH-1:0] lfsr_step(
        input logic [MAX_WIDTH-1:0] state,
        input logic [MAX_WIDTH-1:0] taps,
        input int unsigned          width
    );
        logic [MAX_WIDTH-1:0] mask;
        mask = (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
        return ((state << 1) | MAX_WIDTH'(^(state & taps))) & mask;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register: synchronous reset to SEED, seed loading with an
// all-zero guard, and a single gated step per cycle.
module lfsr_core
    import rng_pkg::*;
#(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_W5,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nxt
);

    assign nxt = WIDTH'(lfsr_step(MAX_WIDTH'(q), MAX_WIDTH'(TAPS), WIDTH));

    // Load outranks stepping; a zero seed would lock the register, so SEED
    // is substituted.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else if (load) begin
            q <= (load_val == '0) ? SEED : load_val;
        end else if (step_en) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/rng_lfsr_gen.sv
// Game randomness source: free-running LFSR gated by a prescaled tick and the
// entropy button, plus a req/valid draw bounded to [1, OUT_MAX].
module rng_lfsr_gen
    import rng_pkg::*;
#(
    parameter int               WIDTH     = 5,
    parameter logic [WIDTH-1:0] TAPS      = TAPS_W5,
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
    parameter int unsigned      DIV       = 2512500,
    parameter int unsigned      OUT_MAX   = 2**WIDTH - 1,
    parameter int unsigned      MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ent_en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_val,
    input  logic             req,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] rnd,
    output logic [WIDTH-1:0] lfsr_q
);

    localparam int               CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int               TRY_W     = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [WIDTH-1:0] OUT_MAX_V = WIDTH'(OUT_MAX);

    logic [CNT_W-1:0] cnt;
    logic             tick;
    state_t           state;
    state_t           state_nx;
    logic [TRY_W-1:0] tries;
    logic             step_en;
    logic             accept;
    logic             give_up;
    logic [WIDTH-1:0] nxt;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .step_en  (step_en),
        .load     (seed_load),
        .load_val (seed_val),
        .q        (lfsr_q),
        .nxt      (nxt)
    );

    // Prescaler is never gated, so tick phase depends only on time since reset.
    assign tick = (cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: default assignment first so no path leaves state_nx unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (req) state_nx = DRAW;
            DRAW: if (seed_load || accept || give_up) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // In DRAW the LFSR steps every cycle, so a coinciding tick adds nothing.
    always_comb begin
        busy    = (state == DRAW);
        step_en = (state == DRAW) || (tick && ent_en);
        accept  = (state == DRAW) && !seed_load && (nxt <= OUT_MAX_V);
        give_up = (state == DRAW) && !seed_load && !accept &&
                  (tries == TRY_W'(MAX_TRIES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rnd   <= '0;
            valid <= 1'b0;
            tries <= '0;
        end else begin
            valid <= accept || give_up;
            if (accept) begin
                rnd <= nxt;
            end else if (give_up) begin
                rnd <= OUT_MAX_V;
            end
            tries <= (state == IDLE) ? '0 : tries + 1'b1;
        end
    end

endmodule

// File: tb/tb_rng_lfsr_gen.sv
// Self-checking bench for rng_lfsr_gen: directed vector table, hand-written
// free-run / period / tick-collision / fallback sequences, randomized run vs model.
module tb_rng_lfsr_gen;

    localparam int W         = 5;
    localparam int DIV       = 4;
    localparam int OUT_MAX   = 5;
    localparam int MAX_TRIES = 8;

    logic         clk = 1'b0;
    logic         rst, ent_en, seed_load, req;
    logic [W-1:0] seed_val;
    logic         busy, valid;
    logic [W-1:0] rnd, lfsr_q;

    logic         f_rst, f_ent_en, f_seed_load, f_req;
    logic [W-1:0] f_seed_val;
    logic         f_busy, f_valid;
    logic [W-1:0] f_rnd, f_lfsr_q;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rng_lfsr_gen #(
        .WIDTH(W), .TAPS(5'b10100), .SEED(5'd1), .DIV(DIV),
        .OUT_MAX(OUT_MAX), .MAX_TRIES(MAX_TRIES)
    ) dut (
        .clk(clk), .rst(rst), .ent_en(ent_en), .seed_load(seed_load),
        .seed_val(seed_val), .req(req), .busy(busy), .valid(valid),
        .rnd(rnd), .lfsr_q(lfsr_q)
    );

    rng_lfsr_gen #(
        .WIDTH(W), .TAPS(5'b10100), .SEED(5'd1), .DIV(DIV),
        .OUT_MAX(OUT_MAX), .MAX_TRIES(2)
    ) dut_fb (
        .clk(clk), .rst(f_rst), .ent_en(f_ent_en), .seed_load(f_seed_load),
        .seed_val(f_seed_val), .req(f_req), .busy(f_busy), .valid(f_valid),
        .rnd(f_rnd), .lfsr_q(f_lfsr_q)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    // Reference step from the rule: double modulo 2**W, plus parity of tapped bits.
    function automatic int ref_step(input int s);
        int fb;
        fb = $countones(s & 'b10100) % 2;
        return ((s * 2) % 32) + fb;
    endfunction

    typedef struct {
        logic       r;
        logic       e;
        logic       l;
        logic [4:0] sv;
        logic       q;
        int         lfsr;
        int         bsy;
        int         vld;
        int         rn;
    } vec_t;

    vec_t tbl[18];

    // Behavioural model state
    int m_lfsr, m_rnd, m_valid, m_busy, m_cnt, m_tries;

    task automatic model_update();
        bit tk;
        if (rst) begin
            m_lfsr = 1; m_rnd = 0; m_valid = 0; m_busy = 0; m_cnt = 0; m_tries = 0;
        end else begin
            tk = (m_cnt == DIV - 1);
            m_cnt = (m_cnt + 1) % DIV;
            m_valid = 0;
            if (m_busy != 0) begin
                if (seed_load) begin
                    m_lfsr = (seed_val == 0) ? 1 : int'(seed_val);
                    m_busy = 0;
                end else begin
                    m_lfsr = ref_step(m_lfsr);
                    m_tries++;
                    if (m_lfsr >= 1 && m_lfsr <= OUT_MAX) begin
                        m_rnd = m_lfsr; m_valid = 1; m_busy = 0;
                    end else if (m_tries == MAX_TRIES) begin
                        m_rnd = OUT_MAX; m_valid = 1; m_busy = 0;
                    end
                end
            end else begin
                if (seed_load) m_lfsr = (seed_val == 0) ? 1 : int'(seed_val);
                else if (tk && ent_en) m_lfsr = ref_step(m_lfsr);
                if (req) begin
                    m_busy = 1; m_tries = 0;
                end
            end
        end
    endtask

    initial begin
        int  exp_l;
        bit  early_one, zero_seen;

        rst = 1'b1; ent_en = 1'b0; seed_load = 1'b0; seed_val = '0; req = 1'b0;
        f_rst = 1'b1; f_ent_en = 1'b0; f_seed_load = 1'b0; f_seed_val = '0; f_req = 1'b0;

        // r e l sv q | lfsr busy valid rnd
        tbl[0]  = '{1, 0, 0, 5'd0, 0,  1, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 5'd0, 1,  1, 1, 0, 0};
        tbl[2]  = '{0, 0, 0, 5'd0, 0,  2, 0, 1, 2};
        tbl[3]  = '{0, 0, 0, 5'd0, 1,  2, 1, 0, 2};
        tbl[4]  = '{0, 0, 0, 5'd0, 0,  4, 0, 1, 4};
        tbl[5]  = '{0, 0, 0, 5'd0, 1,  4, 1, 0, 4};
        tbl[6]  = '{0, 0, 0, 5'd0, 0,  9, 1, 0, 4};
        tbl[7]  = '{0, 0, 0, 5'd0, 0, 18, 1, 0, 4};
        tbl[8]  = '{0, 0, 0, 5'd0, 0,  5, 0, 1, 5};
        tbl[9]  = '{0, 0, 0, 5'd0, 0,  5, 0, 0, 5};
        tbl[10] = '{0, 0, 1, 5'd0, 0,  1, 0, 0, 5};
        tbl[11] = '{0, 0, 1, 5'd7, 0,  7, 0, 0, 5};
        tbl[12] = '{0, 0, 0, 5'd0, 1,  7, 1, 0, 5};
        tbl[13] = '{0, 0, 1, 5'd3, 0,  3, 0, 0, 5};
        tbl[14] = '{0, 0, 0, 5'd0, 0,  3, 0, 0, 5};
        tbl[15] = '{0, 0, 0, 5'd0, 1,  3, 1, 0, 5};
        tbl[16] = '{1, 0, 0, 5'd0, 0,  1, 0, 0, 0};
        tbl[17] = '{0, 0, 0, 5'd0, 0,  1, 0, 0, 0};

        for (int i = 0; i < 18; i++) begin
            rst = tbl[i].r; ent_en = tbl[i].e; seed_load = tbl[i].l;
            seed_val = tbl[i].sv; req = tbl[i].q;
            edge_wait();
            check($sformatf("vec%0d_lfsr", i), 32'(lfsr_q), tbl[i].lfsr);
            check($sformatf("vec%0d_busy", i), 32'(busy), tbl[i].bsy);
            check($sformatf("vec%0d_valid", i), 32'(valid), tbl[i].vld);
            check($sformatf("vec%0d_rnd", i), 32'(rnd), tbl[i].rn);
        end

        // Free-run every 4th cycle, then full period of 31 ticks from seed 1.
        rst = 1'b1; seed_load = 1'b0; req = 1'b0; ent_en = 1'b0;
        edge_wait();
        rst = 1'b0; ent_en = 1'b1;
        exp_l = 1; early_one = 0; zero_seen = 0;
        for (int n = 1; n <= 31 * DIV; n++) begin
            edge_wait();
            if (n % DIV == 0) begin
                exp_l = ref_step(exp_l);
                if (n / DIV < 31 && lfsr_q == 5'd1) early_one = 1;
            end
            if (lfsr_q == 5'd0) zero_seen = 1;
            check($sformatf("freerun_c%0d", n), 32'(lfsr_q), exp_l);
        end
        check("period_returns_to_seed", 32'(lfsr_q), 1);
        check("period_not_early", 32'(early_one), 0);
        check("period_no_zero", 32'(zero_seen), 0);

        // Draw step coinciding with a tick: exactly one step.
        ent_en = 1'b0;
        rst = 1'b1;
        edge_wait();
        rst = 1'b0; ent_en = 1'b1;
        edge_wait();
        edge_wait();
        req = 1'b1;
        edge_wait();
        req = 1'b0;
        check("coll_busy", 32'(busy), 1);
        check("coll_lfsr_pre", 32'(lfsr_q), 1);
        edge_wait();
        check("coll_lfsr_one_step", 32'(lfsr_q), 2);
        check("coll_valid", 32'(valid), 1);
        check("coll_rnd", 32'(rnd), 2);
        for (int n = 0; n < 4; n++) edge_wait();
        check("coll_next_tick", 32'(lfsr_q), 4);
        ent_en = 1'b0;

        // Fallback with MAX_TRIES=2 from seed 00100.
        edge_wait();
        f_rst = 1'b0; f_seed_load = 1'b1; f_seed_val = 5'b00100;
        edge_wait();
        check("fb_seed", 32'(f_lfsr_q), 4);
        f_seed_load = 1'b0; f_req = 1'b1;
        edge_wait();
        f_req = 1'b0;
        check("fb_busy0", 32'(f_busy), 1);
        edge_wait();
        check("fb_step1", 32'(f_lfsr_q), 9);
        check("fb_busy1", 32'(f_busy), 1);
        check("fb_novalid", 32'(f_valid), 0);
        edge_wait();
        check("fb_step2", 32'(f_lfsr_q), 18);
        check("fb_valid", 32'(f_valid), 1);
        check("fb_rnd", 32'(f_rnd), OUT_MAX);
        check("fb_idle", 32'(f_busy), 0);
        edge_wait();
        check("fb_pulse_one", 32'(f_valid), 0);

        // Randomized run against the model.
        rst = 1'b1; ent_en = 1'b0; seed_load = 1'b0; req = 1'b0;
        edge_wait();
        model_update();
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            ent_en    = $urandom_range(0, 1) != 0;
            req       = ($urandom_range(0, 2) == 0);
            seed_load = ($urandom_range(0, 24) == 0);
            seed_val  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            edge_wait();
            model_update();
            check($sformatf("rand%0d_lfsr", n), 32'(lfsr_q), m_lfsr);
            check($sformatf("rand%0d_busy", n), 32'(busy), m_busy);
            check($sformatf("rand%0d_valid", n), 32'(valid), m_valid);
            check($sformatf("rand%0d_rnd", n), 32'(rnd), m_rnd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rng_lfsr_gen.md
Name: rng_lfsr_gen

Overview:
- Parametrised pseudo-random source for obstacle (cactus) spawning and other game randomness.
- A Fibonacci LFSR of configurable width and tap mask free-runs on a prescaled tick while an entropy input (the jump button) is held.
- Provides seed loading with lock-up protection, plus a req/valid draw port that returns a value bounded to [1, OUT_MAX] by rejection sampling with a fixed fallback.

Parameters:
- WIDTH, 5: LFSR and output width (3..16).
- TAPS, 5'b10100: feedback mask; new bit0 = XOR of state bits whose mask bit is 1 (default is maximal length, period 31).
- SEED, 1: reset and substitute seed; must be nonzero.
- DIV, 2512500: prescaler period in clk cycles between free-run steps. Counter width is $clog2(DIV).
- OUT_MAX, 2**WIDTH-1: inclusive upper bound of drawn values (1..2**WIDTH-1).
- MAX_TRIES, 8: LFSR steps per draw before fallback (>=1).

Ports:
- clk        in   1      system clock
- rst        in   1      synchronous active-high reset
- ent_en     in   1      entropy gate (button); free-run steps occur only while high
- seed_load  in   1      single-cycle load strobe
- seed_val   in   WIDTH  seed value, sampled when seed_load=1
- req        in   1      draw request, sampled only when busy=0
- busy       out  1      draw in progress
- valid      out  1      single-cycle pulse: rnd updated
- rnd        out  WIDTH  last drawn value (held between draws)
- lfsr_q     out  WIDTH  raw LFSR state

Behaviour:
- Reset (synchronous, sampled on clk rising edge):
  - lfsr_q=SEED, rnd=0, valid=0, busy=0, prescaler=0, tries=0, FSM=IDLE.
  - A reset asserted mid-draw aborts the draw with no valid pulse.
- Step function: next = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)}. At most one step per cycle.
- Prescaler:
  - Counts 0..DIV-1 every cycle and wraps; it is never gated.
  - tick=1 in the cycle the count equals DIV-1.
- Free-run: if tick && ent_en && FSM==IDLE, lfsr_q <= next. A tick arriving during a draw is dropped, not queued.
- Seed load: highest priority after reset.
  - seed_load=1 sets lfsr_q <= seed_val, or SEED if seed_val==0 (lock-up guard).
  - A seed load in IDLE suppresses that cycle's step.
  - A seed load in DRAW aborts the draw: FSM->IDLE, busy=0, no valid.
- FSM:
  - IDLE: req=1 -> DRAW, busy<=1, tries<=0.
  - DRAW: each cycle lfsr_q <= next, then:
    - if next<=OUT_MAX: rnd<=next, valid<=1, busy<=0 -> IDLE.
    - else if tries==MAX_TRIES-1: rnd<=OUT_MAX (fallback), valid<=1, busy<=0 -> IDLE.
    - otherwise tries<=tries+1 and remain in DRAW.
- Latency and handshake:
  - req sampled at edge k; valid is high in the cycle after edge k+t, where t = number of steps (1..MAX_TRIES).
  - Minimum latency is 2 cycles from the req edge.
  - req while busy=1 is ignored. req held high re-triggers on the cycle after valid.
- valid is exactly one cycle wide. rnd changes only together with valid (and on reset).
- Zero state is unreachable: seed guard plus nonzero SEED.

Decomposition:
- Package rng_pkg holds:
  - the state enum (IDLE, DRAW);
  - the lfsr_step(state, taps) function;
  - default TAPS constants per width (5:'b10100, 8:'b10111000, 16:'h B400).
- Natural sub-module: lfsr_core (state register, step, seed/guard logic, step enable input). The FSM and prescaler stay in rng_lfsr_gen.

Test Plan (DIV=4, WIDTH=5, TAPS=5'b10100, SEED=1 unless stated):
- Reset, then ent_en=1 for 20 cycles -> lfsr_q steps every 4th cycle: 00010, 00100, 01001, 10010, 00101.
- Period: ent_en=1 for 31 ticks from seed 1 -> lfsr_q returns to 00001 exactly at tick 31, not earlier; no all-zero state.
- OUT_MAX=5, reset, three draws with ent_en=0:
  - rnd=2 (valid 2 cycles after req), then rnd=4 (2 cycles), then rnd=5 (4 cycles; 9 and 18 rejected).
  - busy is high throughout each draw.
- Fallback, OUT_MAX=5, MAX_TRIES=2: load seed 00100, draw -> steps to 01001, 10010; rnd=5, lfsr_q=10010, latency 3 cycles.
- seed_load with seed_val=0 -> lfsr_q=00001. seed_load during DRAW -> busy drops next cycle, no valid pulse, lfsr_q=seed_val.
- Tick coincides with DRAW step, and rst during DRAW -> exactly one step per cycle. Reset clears busy, valid, rnd and lfsr_q=SEED on the next edge.
